fpga_clk_div_gen: RTL and testbench

Parametrised successor to the fixed FPGA clock generator. It produces NCH independent, APB-programmable clock-enable strobes from the single board clock `pad_clk`. Each channel has a runtime divide ratio, an enable bit and an external gate input. Ratio changes are glitch-free and take effect only on a period boundary. The block sits in the FPGA system wrapper between the pad clock and the CPU/peripheral/PMU/WIC clock-enable consumers. It is one clock domain: no derived clocks, enables only.

---
 rtl/fpga_clk_gen_pkg.sv | 29 ++
 rtl/fpga_clk_div_ch.sv | 75 +++++++
 rtl/fpga_clk_div_gen.sv | 125 ++++++++++++
 tb/tb_fpga_clk_div_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_clk_gen_pkg.sv
// fpga_clk_gen_pkg
// Register map constants and decode types shared by the clock-enable
// generator top level and its channel slices.

package fpga_clk_gen_pkg;

    // APB data bus width
    localparam int APB_DW       = 32;

    // Byte offsets of the programmable registers
    localparam int CTRL_OFS     = 'h00;
    localparam int RATIO_BASE   = 'h04;
    localparam int RATIO_STRIDE = 4;
    localparam int STATUS_OFS   = 'h40;

    // Which register class an APB address selects
    typedef enum logic [1:0] {
        REG_NONE,
        REG_CTRL,
        REG_RATIO,
        REG_STATUS
    } regSel_e;

    // Byte offset of the RATIO register belonging to channel idx
    function automatic int ratioOffset(input int idx);
        return RATIO_BASE + RATIO_STRIDE * idx;
    endfunction

endpackage

// File: rtl/fpga_clk_div_ch.sv
// fpga_clk_div_ch
// One clock-enable channel: a period counter running 0..active ratio, an
// active/pending ratio pair so that ratio changes only land on a period
// boundary, and the registered strobe output.

module fpga_clk_div_ch #(
    parameter int DIV_W = 8
) (
    input  logic             pad_clk,
    input  logic             clkrst,
    input  logic             i_enable,
    input  logic             i_gate,
    input  logic             i_wrEn,
    input  logic [DIV_W-1:0] i_wrData,
    output logic             o_clkEn,
    output logic             o_ratioPend,
    output logic [DIV_W-1:0] o_activeRatio
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] r_pendVal;
    logic             r_pend;
    logic             r_clkEn;
    logic             w_terminal;

    // The last cycle of a period is the one where the counter reaches the active ratio
    assign w_terminal = (r_cnt == r_active);

    // Counter, ratio hand-over and strobe: a disabled channel parks at count 0
    // so the first period after re-enable is a full one; a write that lands on
    // the terminal cycle skips the pending stage so that boundary is not missed
    always_ff @(posedge pad_clk) begin
        if (clkrst) begin
            r_cnt     <= '0;
            r_active  <= '0;
            r_pendVal <= '0;
            r_pend    <= 1'b0;
            r_clkEn   <= 1'b0;
        end else if (!i_enable) begin
            r_cnt   <= '0;
            r_clkEn <= 1'b0;
            if (i_wrEn) begin
                r_pendVal <= i_wrData;
                r_pend    <= 1'b1;
            end else if (r_pend) begin
                r_active <= r_pendVal;
                r_pend   <= 1'b0;
            end
        end else begin
            r_clkEn <= i_gate & w_terminal;
            if (w_terminal) begin
                r_cnt <= '0;
                if (i_wrEn) begin
                    r_active <= i_wrData;
                    r_pend   <= 1'b0;
                end else if (r_pend) begin
                    r_active <= r_pendVal;
                    r_pend   <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
                if (i_wrEn) begin
                    r_pendVal <= i_wrData;
                    r_pend    <= 1'b1;
                end
            end
        end
    end

    assign o_clkEn       = r_clkEn;
    assign o_ratioPend   = r_pend;
    assign o_activeRatio = r_active;

endmodule

// File: rtl/fpga_clk_div_gen.sv
// fpga_clk_div_gen
// NCH independent, APB-programmable clock-enable strobes derived from the
// single pad clock. Holds the APB decode, the CTRL enable register and the
// registered read path; the per-channel timing lives in fpga_clk_div_ch.

module fpga_clk_div_gen
    import fpga_clk_gen_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int DIV_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              pad_clk,
    input  logic              clkrst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [APB_DW-1:0] pwdata,
    output logic [APB_DW-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [NCH-1:0]    gate_en,
    output logic [NCH-1:0]    clk_en,
    output logic [NCH-1:0]    ratio_pend
);

    regSel_e           w_regSel;
    logic [NCH-1:0]    w_ratioHit;
    logic              w_setup;
    logic              w_wrCommit;
    logic [APB_DW-1:0] w_rdData;
    logic [DIV_W-1:0]  w_activeRatio [NCH];
    logic              w_unusedPwdata;

    logic [NCH-1:0]    r_ctrl;
    logic [APB_DW-1:0] r_prdata;
    logic              r_pslverr;

    // Address decode; STATUS is matched before the RATIO window so that a
    // 16-channel build, whose last RATIO slot would sit on 0x40, keeps STATUS
    always_comb begin
        w_regSel   = REG_NONE;
        w_ratioHit = '0;
        if (paddr == ADDR_W'(CTRL_OFS)) begin
            w_regSel = REG_CTRL;
        end else if (paddr == ADDR_W'(STATUS_OFS)) begin
            w_regSel = REG_STATUS;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (paddr == ADDR_W'(ratioOffset(i))) begin
                    w_regSel      = REG_RATIO;
                    w_ratioHit[i] = 1'b1;
                end
            end
        end
    end

    assign w_setup    = psel & ~penable;
    assign w_wrCommit = psel & penable & pwrite & (w_regSel != REG_NONE);

    // Only the low ratio/enable bits of the write bus are stored
    assign w_unusedPwdata = ^pwdata;

    // CTRL enables every channel out of reset so the block behaves like the
    // legacy always-on generator until software says otherwise
    always_ff @(posedge pad_clk) begin
        if (clkrst) begin
            r_ctrl <= '1;
        end else if (w_wrCommit && (w_regSel == REG_CTRL)) begin
            r_ctrl <= pwdata[NCH-1:0];
        end
    end

    // Read mux; RATIO reads show the ratio the counter is actually using
    always_comb begin
        w_rdData = '0;
        case (w_regSel)
            REG_CTRL:   w_rdData[NCH-1:0] = r_ctrl;
            REG_STATUS: w_rdData[NCH-1:0] = ratio_pend;
            REG_RATIO: begin
                for (int i = 0; i < NCH; i++) begin
                    if (w_ratioHit[i]) begin
                        w_rdData[DIV_W-1:0] = w_activeRatio[i];
                    end
                end
            end
            default: w_rdData = '0;
        endcase
    end

    // Read data and error are captured in the setup phase so they are stable
    // for the whole access phase and drop back to zero afterwards
    always_ff @(posedge pad_clk) begin
        if (clkrst) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            r_prdata  <= (w_setup && !pwrite) ? w_rdData : '0;
            r_pslverr <= w_setup && (w_regSel == REG_NONE);
        end
    end

    assign prdata  = r_prdata;
    assign pslverr = r_pslverr;
    assign pready  = 1'b1;

    // One divider slice per output channel
    for (genvar g = 0; g < NCH; g++) begin : gCh
        fpga_clk_div_ch #(
            .DIV_W(DIV_W)
        ) uCh (
            .pad_clk      (pad_clk),
            .clkrst       (clkrst),
            .i_enable     (r_ctrl[g]),
            .i_gate       (gate_en[g]),
            .i_wrEn       (w_wrCommit & w_ratioHit[g]),
            .i_wrData     (pwdata[DIV_W-1:0]),
            .o_clkEn      (clk_en[g]),
            .o_ratioPend  (ratio_pend[g]),
            .o_activeRatio(w_activeRatio[g])
        );
    end

endmodule

// File: tb/tb_fpga_clk_div_gen.sv
// tb_fpga_clk_div_gen
// Directed steps followed by random APB/gate traffic. Expected outputs come
// from a model that tracks, per channel, the absolute cycle of the next
// period end and the active/pending ratio values.

module tb_fpga_clk_div_gen;

    localparam int NCH    = 4;
    localparam int DIV_W  = 8;
    localparam int ADDR_W = 8;

    logic              pad_clk = 1'b0;
    logic              clkrst  = 1'b1;
    logic              psel    = 1'b0;
    logic              penable = 1'b0;
    logic              pwrite  = 1'b0;
    logic [ADDR_W-1:0] paddr   = '0;
    logic [31:0]       pwdata  = '0;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic [NCH-1:0]    gate_en = '1;
    logic [NCH-1:0]    clk_en;
    logic [NCH-1:0]    ratio_pend;

    fpga_clk_div_gen #(
        .NCH(NCH), .DIV_W(DIV_W), .ADDR_W(ADDR_W)
    ) dut (
        .pad_clk(pad_clk), .clkrst(clkrst), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .gate_en(gate_en),
        .clk_en(clk_en), .ratio_pend(ratio_pend)
    );

    // Free-running board clock
    always #5 pad_clk = ~pad_clk;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;
    int cyc        = 0;

    // Reference model state
    bit [NCH-1:0]   mCtrl;
    int             mActive   [NCH];
    int             mPendVal  [NCH];
    bit             mPend     [NCH];
    int             mNextTerm [NCH];
    logic [NCH-1:0] expClkEn;
    logic [NCH-1:0] expPend;
    logic [31:0]    expPrdata;
    logic           expSlverr;

    int lastStrobe [NCH];
    int gapObs     [NCH];

    function automatic bit isMapped(input int a);
        if (a % 4 != 0) return 1'b0;
        if (a == 'h00 || a == 'h40) return 1'b1;
        return (a >= 4) && ((a - 4) / 4 < NCH);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock edge: predict outputs from the inputs present at the
    // edge, then compare every DUT output shortly after the edge
    task automatic tick();
        int   addr;
        bit   mapped;
        bit   wrCommit;
        bit   wr;
        bit   termNow;
        int   d;
        int   newR;
        logic [31:0] rd;
        addr     = int'(paddr);
        mapped   = isMapped(addr);
        wrCommit = psel && penable && pwrite && mapped;
        d        = int'(pwdata[DIV_W-1:0]);
        cyc++;
        rd = '0;
        if (addr == 'h00) rd = 32'(mCtrl);
        else if (addr == 'h40) begin
            for (int i = 0; i < NCH; i++) rd[i] = mPend[i];
        end else if (mapped) rd = 32'(mActive[(addr - 4) / 4]);
        if (clkrst) begin
            mCtrl = '1;
            for (int ch = 0; ch < NCH; ch++) begin
                mActive[ch] = 0; mPend[ch] = 1'b0; mPendVal[ch] = 0;
                mNextTerm[ch] = cyc + 1;
            end
            expClkEn = '0; expPrdata = '0; expSlverr = 1'b0;
        end else begin
            expPrdata = (psel && !penable && !pwrite) ? rd : 32'h0;
            expSlverr = psel && !penable && !mapped;
            for (int ch = 0; ch < NCH; ch++) begin
                wr = wrCommit && (addr == 4 + 4 * ch);
                if (mCtrl[ch]) begin
                    termNow = (cyc == mNextTerm[ch]);
                    expClkEn[ch] = gate_en[ch] && termNow;
                    if (termNow) begin
                        newR = wr ? d : (mPend[ch] ? mPendVal[ch] : mActive[ch]);
                        mActive[ch] = newR;
                        mPend[ch] = 1'b0;
                        mNextTerm[ch] = cyc + newR + 1;
                    end else if (wr) begin
                        mPendVal[ch] = d; mPend[ch] = 1'b1;
                    end
                end else begin
                    expClkEn[ch] = 1'b0;
                    if (wr) begin
                        mPendVal[ch] = d; mPend[ch] = 1'b1;
                    end else if (mPend[ch]) begin
                        mActive[ch] = mPendVal[ch]; mPend[ch] = 1'b0;
                    end
                    mNextTerm[ch] = cyc + 1 + mActive[ch];
                end
            end
            if (wrCommit && addr == 'h00) mCtrl = pwdata[NCH-1:0];
        end
        for (int i = 0; i < NCH; i++) expPend[i] = mPend[i];
        @(posedge pad_clk);
        #1;
        checkOutput("clk_en", 32'(clk_en), 32'(expClkEn));
        checkOutput("ratio_pend", 32'(ratio_pend), 32'(expPend));
        checkOutput("prdata", prdata, expPrdata);
        checkOutput("pslverr", 32'(pslverr), 32'(expSlverr));
        checkOutput("pready", 32'(pready), 32'h1);
        for (int i = 0; i < NCH; i++) begin
            if (clk_en[i]) begin
                gapObs[i] = cyc - lastStrobe[i];
                lastStrobe[i] = cyc;
            end
        end
    endtask

    task automatic apbWrite(input int addr, input logic [31:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = ADDR_W'(addr); pwdata = data;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apbRead(input int addr, output logic [31:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = ADDR_W'(addr);
        tick();
        data = prdata;
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic waitStrobe(input int ch, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            if (clk_en[ch]) seen = 1'b1;
        end
        checkOutput($sformatf("strobe_seen_ch%0d", ch), 32'(seen), 32'h1);
    endtask

    // One random bus/gate action
    task automatic applyStimulus();
        logic [31:0] rd;
        int sel;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0, 1, 2: repeat (int'($urandom_range(1, 4))) tick();
            3: begin gate_en = NCH'($urandom); tick(); end
            4, 5: apbWrite(4 + 4 * int'($urandom_range(0, NCH - 1)), 32'($urandom_range(0, 6)));
            6: apbWrite('h00, $urandom | $urandom);
            7: apbRead(4 * int'($urandom_range(0, 17)), rd);
            8: begin
                if ($urandom_range(0, 1) == 0) apbRead(int'($urandom_range(0, 255)), rd);
                else apbWrite(int'($urandom_range(0, 255)), $urandom);
            end
            default: apbWrite('h40, $urandom);
        endcase
    endtask

    initial begin
        logic [31:0] rd;
        int s;
        int n;
        for (int i = 0; i < NCH; i++) begin
            lastStrobe[i] = 0; gapObs[i] = 0;
        end

        // Reset, then idle bus: every ratio-0 channel strobes continuously
        repeat (2) tick();
        clkrst = 1'b0;
        repeat (5) tick();
        checkOutput("rst_clk_en_all", 32'(clk_en), 32'hF);
        checkOutput("rst_prdata", prdata, 32'h0);

        // RATIO_0 = 3 written while channel 0 is at its boundary
        apbWrite('h04, 32'd3);
        repeat (12) tick();
        apbRead('h04, rd);
        checkOutput("ratio0_read", rd, 32'd3);

        // 3 -> 1 -> 5 inside one period: last write wins, 1 never applied
        waitStrobe(0, 8);
        repeat (3) tick();
        apbWrite('h04, 32'd1);
        apbWrite('h04, 32'd5);
        checkOutput("ratio0_pend_overwrite", 32'(ratio_pend[0]), 32'h1);
        waitStrobe(0, 10);
        checkOutput("ratio0_gap_old", 32'(gapObs[0]), 32'd4);
        waitStrobe(0, 10);
        checkOutput("ratio0_gap_new1", 32'(gapObs[0]), 32'd6);
        waitStrobe(0, 10);
        checkOutput("ratio0_gap_new2", 32'(gapObs[0]), 32'd6);
        apbRead('h04, rd);
        checkOutput("ratio0_read_new", rd, 32'd5);

        // Gate channel 1 for 10 cycles at ratio 2; phase must survive
        apbWrite('h08, 32'd2);
        waitStrobe(1, 6);
        s = cyc;
        gate_en[1] = 1'b0;
        repeat (10) tick();
        gate_en[1] = 1'b1;
        waitStrobe(1, 6);
        checkOutput("gate_phase", 32'((cyc - s) % 3), 32'd0);

        // Disable channel 2, change its ratio, re-enable
        apbWrite('h00, 32'hB);
        apbWrite('h0C, 32'd7);
        repeat (4) tick();
        checkOutput("ch2_disabled", 32'(clk_en[2]), 32'h0);
        apbRead('h0C, rd);
        checkOutput("ch2_ratio_applied", rd, 32'd7);
        apbWrite('h00, 32'hF);
        n = cyc;
        waitStrobe(2, 20);
        checkOutput("ch2_reenable_latency", 32'(cyc - n), 32'd8);

        // Unmapped access
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h80;
        tick();
        rd = prdata;
        checkOutput("unmapped_pslverr", 32'(pslverr), 32'h1);
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0;
        checkOutput("unmapped_rdata", rd, 32'h0);
        apbWrite('h80, 32'h0);
        apbRead('h00, rd);
        checkOutput("ctrl_after_unmapped", rd, 32'hF);

        // Reset mid-period with a write possibly pending
        apbWrite('h04, 32'd2);
        tick();
        clkrst = 1'b1;
        tick();
        checkOutput("midrst_pend", 32'(ratio_pend), 32'h0);
        checkOutput("midrst_clk_en", 32'(clk_en), 32'h0);
        clkrst = 1'b0;
        tick();
        checkOutput("post_rst_clk_en", 32'(clk_en), 32'hF);
        apbRead('h04, rd);
        checkOutput("post_rst_ratio0", rd, 32'h0);
        apbRead('h40, rd);
        checkOutput("post_rst_status", rd, 32'h0);

        // Random traffic against the model
        for (int it = 0; it < 400; it++) applyStimulus();
        gate_en = '1;
        apbWrite('h00, 32'hF);
        repeat (20) tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
